instr_encoder: RTL and testbench
================================

# instr_encoder

Converts decoded operation requests (ALU op, operand select, register indices, immediate) into RV32I R-type/I-type instruction words and streams them into instruction memory at consecutive word addresses. It is the inverse of the core's instruction-decode controller and serves as the program-loader path for self-test and bring-up. A one-entry output register sits between a valid/ready request port and a valid/ready memory-write port.

## Interface
- ADDR_W, 8: instruction-memory word-address width
- BASE_ADDR, 0: first write address after `start`
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin or restart a program; honoured only in IDLE or DONE
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_aluop  in  4  ALU op code, shared package encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, NULL 10
- in_sel_b  in  1  0 = register operand (R-type), 1 = immediate (I-type)
- in_rd, in_rs1, in_rs2  in  5 each  register indices; in_rs2 is ignored when in_sel_b=1
- in_imm  in  12  I-type immediate
- in_last  in  1  final request of the program
- out_valid  out  1  memory write valid
- out_ready  in  1  memory accepts the write
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  word address
- done  out  1  program complete (level)
- err_ovf  out  1  sticky: address space exhausted before in_last
- err_ill  out  1  sticky: illegal request seen (macro-enabled only)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. `start` moves to RUN.
  - RUN: in_ready = !(out_valid && !out_ready) && !(out_valid && out_addr == all-ones).
  - Accepting a request with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. The output handshake moves to DONE. If the output register is empty, DRAIN moves to DONE on the next cycle.
  - DONE: done=1. `start` clears done, err_ovf and err_ill, reloads out_addr with BASE_ADDR, and moves to RUN.
- Encoding:
  - R-type (sel_b=0): opcode 0110011.
  - I-type (sel_b=1): opcode 0010011, imm field = in_imm.
  - funct3: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - funct7 = 0100000 for SUB and SRA; 0000000 otherwise.
  - I-type shifts: imm[11:5] = funct7 and imm[4:0] = in_imm[4:0], so SRAI is encoded distinctly from SRLI.
- Illegal requests: aluop ≥ 10, or SUB with sel_b=1.
- out_addr increments by 1 on each output handshake, with no wrap.
- A handshake at out_addr = all-ones whose word was not the last forces DONE with err_ovf=1.
- `start` in RUN or DRAIN is ignored.
- Asserting rst_n low at any point returns every register to its reset value. Any buffered word is discarded.

## Timing
- Reset values: state IDLE, in_ready 0, out_valid 0, out_instr 0, out_addr BASE_ADDR, done 0, err_ovf 0, err_ill 0.
- Latency: request handshake in cycle N gives out_valid=1 in cycle N+1.
- Full throughput of 1 word/cycle when out_ready is held high.
- out_instr and out_addr stay stable while out_valid && !out_ready.
- A simultaneous output handshake and input acceptance is allowed; the register refills in the same edge.
- done rises in the cycle after the final output handshake.

## Configuration
- ENC_ILLEGAL_CHECK_EN defined:
  - An illegal request is accepted but produces no output word and does not advance out_addr.
  - err_ill is set.
  - If the request had in_last=1, DRAIN/DONE sequencing still applies.
- ENC_ILLEGAL_CHECK_EN undefined:
  - An illegal request is encoded as NOP 0x00000013 and written normally.
  - err_ill is tied to 0.

## Structure
- Shared package ctrl_pkg, also used by the decode controller, holds:
  - aluop_t enum
  - OPC_RTYPE and OPC_ITYPE constants
  - funct3 constants
  - FUNCT7_ALT and FUNCT7_BASE
  - NOP_INSTR
- Sub-module instr_enc_comb holds the pure combinational encoding (request fields to 32-bit word plus illegal flag).
- The top level holds the FSM, the output register and the address counter.

## Test plan
- start; ADD rd=3 rs1=1 rs2=2 sel_b=0 -> out_instr 0x002081B3 at out_addr 0 in the next cycle.
- SUB with the same fields -> 0x402081B3. SRA sel_b=1 rd=5 rs1=6 imm=3 -> 0x40335293. ADDI rd=1 rs1=0 imm=0xFFF -> 0xFFF00093.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> out_instr and out_addr unchanged and in_ready=0; release -> one write, and the next word follows the next cycle.
- ADDR_W=2, 5 requests without in_last -> writes at addresses 0..3, 5th request not accepted, done=1 and err_ovf=1; start -> out_addr 0, flags cleared.
- in_last on the 3rd request -> 3 writes, done=1 one cycle after the 3rd handshake, in_ready=0 in DRAIN and DONE.
- aluop=10 request -> macro defined: no write, out_addr unchanged, err_ill=1. Macro undefined: 0x00000013 written.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control encodings: ALU op codes and RV32I OP/OP-IMM field constants,
// used by the decode controller and by instr_encoder.
package ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_NULL = 4'd10
   } aluop_t;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE = 7'b0010011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_enc_comb.sv
// Pure combinational encoder: ALU request fields to an RV32I OP/OP-IMM word.
// Illegal requests yield NOP_INSTR and raise `illegal`.
module instr_enc_comb
   import ctrl_pkg::*;
(
   input  logic [3:0]  aluop,
   input  logic        sel_b,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [11:0] imm,
   output logic [31:0] instr,
   output logic        illegal
);

   aluop_t      op;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_shift;
   logic [11:0] imm_field;

   assign op = aluop_t'(aluop);

   always_comb begin
      funct3   = F3_ADD_SUB;
      funct7   = FUNCT7_BASE;
      is_shift = 1'b0;
      illegal  = 1'b0;
      case (op)
         ALU_ADD:  funct3 = F3_ADD_SUB;
         ALU_SUB: begin
            funct3  = F3_ADD_SUB;
            funct7  = FUNCT7_ALT;
            illegal = sel_b;
         end
         ALU_SLL: begin
            funct3   = F3_SLL;
            is_shift = 1'b1;
         end
         ALU_SLT:  funct3 = F3_SLT;
         ALU_SLTU: funct3 = F3_SLTU;
         ALU_XOR:  funct3 = F3_XOR;
         ALU_SRL: begin
            funct3   = F3_SRL_SRA;
            is_shift = 1'b1;
         end
         ALU_SRA: begin
            funct3   = F3_SRL_SRA;
            funct7   = FUNCT7_ALT;
            is_shift = 1'b1;
         end
         ALU_OR:   funct3 = F3_OR;
         ALU_AND:  funct3 = F3_AND;
         default:  illegal = 1'b1;
      endcase
   end

   // Immediate shifts carry funct7 in imm[11:5] so SRAI differs from SRLI
   assign imm_field = is_shift ? {funct7, imm[4:0]} : imm;

   always_comb begin
      if (illegal)
         instr = NOP_INSTR;
      else if (sel_b)
         instr = {imm_field, rs1, funct3, rd, OPC_ITYPE};
      else
         instr = {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};
   end

endmodule

// File: rtl/instr_encoder.sv
// Program-loader path: encodes ALU requests and streams them to instruction
// memory. Build macro ENC_ILLEGAL_CHECK_EN drops illegal requests and flags err_ill.
module instr_encoder
   import ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_aluop,
   input  logic              in_sel_b,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [11:0]       in_imm,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              done,
   output logic              err_ovf,
   output logic              err_ill
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] enc_instr;
   logic        enc_illegal;
   logic        in_fire, out_fire, addr_max, start_ok, drop_word, load_word, ovf_set;

   instr_enc_comb u_enc (
      .aluop   (in_aluop),
      .sel_b   (in_sel_b),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .instr   (enc_instr),
      .illegal (enc_illegal)
   );

   assign addr_max  = (out_addr == '1);
   assign out_fire  = out_valid && out_ready;
   assign in_fire   = in_valid && in_ready;
   assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
   // A word buffered in RUN is never the last one, so leaving the top address here is overflow
   assign ovf_set   = (state == ST_RUN) && out_fire && addr_max;
   assign load_word = in_fire && !drop_word;
   assign done      = (state == ST_DONE);

`ifdef ENC_ILLEGAL_CHECK_EN
   logic err_ill_q;

   assign drop_word = enc_illegal;
   assign err_ill   = err_ill_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_ill_q <= 1'b0;
      else if (start_ok)
         err_ill_q <= 1'b0;
      else if (in_fire && enc_illegal)
         err_ill_q <= 1'b1;
   end
`else
   logic unused_illegal;

   assign unused_illegal = enc_illegal;
   assign drop_word      = 1'b0;
   assign err_ill        = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         ST_IDLE:
            if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            in_ready = !(out_valid && !out_ready) && !(out_valid && addr_max);
            if (in_valid && in_ready && in_last)
               state_nxt = ST_DRAIN;
            else if (ovf_set)
               state_nxt = ST_DONE;
         end
         ST_DRAIN:
            if (!out_valid || out_ready) state_nxt = ST_DONE;
         ST_DONE:
            if (start) state_nxt = ST_RUN;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= BASE;
         err_ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            out_addr <= BASE;
            err_ovf  <= 1'b0;
         end else begin
            if (out_fire && !addr_max)
               out_addr <= out_addr + 1'b1;
            if (ovf_set)
               err_ovf <= 1'b1;
         end
         if (load_word) begin
            out_valid <= 1'b1;
            out_instr <= enc_instr;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder (ADDR_W=8 main instance plus
// an ADDR_W=2 instance for address exhaustion).
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, in_valid, in_sel_b, in_last, out_ready;
   logic [3:0]  in_aluop;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [11:0] in_imm;

   logic        in_ready, out_valid, done, err_ovf, err_ill;
   logic [31:0] out_instr;
   logic [7:0]  out_addr;

   logic        in_ready_s, out_valid_s, done_s, err_ovf_s, err_ill_s;
   logic [31:0] out_instr_s;
   logic [1:0]  out_addr_s;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct packed {
      logic [3:0]  aluop;
      logic        sel_b;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs[NV];
   vec_t v_ill, v_subi;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(in_aluop), .in_sel_b(in_sel_b), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .done(done),
      .err_ovf(err_ovf), .err_ill(err_ill)
   );

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_aluop(in_aluop), .in_sel_b(in_sel_b), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_instr(out_instr_s), .out_addr(out_addr_s), .done(done_s),
      .err_ovf(err_ovf_s), .err_ill(err_ill_s)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input vec_t v, input logic last);
      in_aluop = v.aluop;
      in_sel_b = v.sel_b;
      in_rd    = v.rd;
      in_rs1   = v.rs1;
      in_rs2   = v.rs2;
      in_imm   = v.imm;
      in_last  = last;
      in_valid = 1'b1;
   endtask

   initial begin
      int unsigned acc;

      //           aluop sel rd     rs1    rs2    imm       expected
      vecs[0]  = '{4'd0, 1'b0, 5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3}; // ADD
      vecs[1]  = '{4'd1, 1'b0, 5'd3,  5'd1,  5'd2,  12'h000, 32'h402081B3}; // SUB
      vecs[2]  = '{4'd7, 1'b1, 5'd5,  5'd6,  5'd0,  12'h003, 32'h40335293}; // SRAI
      vecs[3]  = '{4'd0, 1'b1, 5'd1,  5'd0,  5'd0,  12'hFFF, 32'hFFF00093}; // ADDI
      vecs[4]  = '{4'd2, 1'b0, 5'd7,  5'd8,  5'd9,  12'h000, 32'h009413B3}; // SLL
      vecs[5]  = '{4'd4, 1'b1, 5'd10, 5'd11, 5'd0,  12'h123, 32'h1235B513}; // SLTIU
      vecs[6]  = '{4'd6, 1'b1, 5'd2,  5'd3,  5'd0,  12'hFE5, 32'h0051D113}; // SRLI
      vecs[7]  = '{4'd9, 1'b0, 5'd31, 5'd31, 5'd31, 12'h000, 32'h01FFFFB3}; // AND
      vecs[8]  = '{4'd5, 1'b1, 5'd4,  5'd5,  5'd31, 12'h800, 32'h8002C213}; // XORI
      vecs[9]  = '{4'd3, 1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h003120B3}; // SLT
      vecs[10] = '{4'd8, 1'b0, 5'd6,  5'd7,  5'd8,  12'h000, 32'h0083E333}; // OR
      vecs[11] = '{4'd7, 1'b0, 5'd1,  5'd1,  5'd1,  12'h000, 32'h4010D0B3}; // SRA
      v_ill    = '{4'd10, 1'b0, 5'd1, 5'd2,  5'd3,  12'h000, 32'h00000013};
      v_subi   = '{4'd1, 1'b1, 5'd1,  5'd2,  5'd0,  12'h001, 32'h00000013};

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_aluop = '0; in_sel_b = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_imm = '0; in_last = 1'b0;

      cyc();
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_instr", out_instr, 0);
      chk("rst out_addr", out_addr, 0);
      chk("rst done", done, 0);
      chk("rst err_ovf", err_ovf, 0);
      chk("rst err_ill", err_ill, 0);
      rst_n = 1'b1;
      cyc();
      chk("idle in_ready", in_ready, 0);

      // Back-to-back stream through the whole table, last entry ends the program
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < NV; i++) begin
         chk($sformatf("tbl%0d in_ready", i), in_ready, 1);
         drive(vecs[i], (i == NV - 1));
         cyc();
         chk($sformatf("tbl%0d out_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d out_instr", i), out_instr, vecs[i].exp);
         chk($sformatf("tbl%0d out_addr", i), out_addr, i);
      end
      in_valid = 1'b0;
      chk("drain in_ready", in_ready, 0);
      chk("drain done", done, 0);
      cyc();
      chk("tbl done", done, 1);
      chk("tbl done out_valid", out_valid, 0);
      chk("tbl done in_ready", in_ready, 0);
      chk("tbl done err_ovf", err_ovf, 0);

      // Backpressure, restart from DONE, start ignored in RUN, in_last on third request
      start = 1'b1; cyc(); start = 1'b0;
      chk("restart out_addr", out_addr, 0);
      chk("restart done", done, 0);
      out_ready = 1'b0;
      drive(vecs[0], 1'b0);
      cyc();
      chk("bp out_valid", out_valid, 1);
      chk("bp out_instr", out_instr, vecs[0].exp);
      drive(vecs[1], 1'b0);
      chk("bp in_ready", in_ready, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("hold%0d out_valid", k), out_valid, 1);
         chk($sformatf("hold%0d out_instr", k), out_instr, vecs[0].exp);
         chk($sformatf("hold%0d out_addr", k), out_addr, 0);
         chk($sformatf("hold%0d in_ready", k), in_ready, 0);
      end
      out_ready = 1'b1;
      cyc();
      chk("rel out_instr", out_instr, vecs[1].exp);
      chk("rel out_addr", out_addr, 1);
      start = 1'b1;
      drive(vecs[2], 1'b1);
      cyc();
      chk("l3 out_instr", out_instr, vecs[2].exp);
      chk("l3 out_addr", out_addr, 2);
      chk("l3 drain in_ready", in_ready, 0);
      chk("l3 drain done", done, 0);
      in_valid = 1'b0; start = 1'b0;
      cyc();
      chk("l3 done", done, 1);
      chk("l3 done in_ready", in_ready, 0);
      chk("l3 out_valid", out_valid, 0);
      cyc();
      chk("l3 done hold", done, 1);
      chk("l3 done hold in_ready", in_ready, 0);

      // Illegal requests
      start = 1'b1; cyc(); start = 1'b0;
      drive(v_ill, 1'b0);
      cyc();
`ifdef ENC_ILLEGAL_CHECK_EN
      chk("ill out_valid", out_valid, 0);
      chk("ill out_addr", out_addr, 0);
      chk("ill err_ill", err_ill, 1);
`else
      chk("ill out_valid", out_valid, 1);
      chk("ill out_instr", out_instr, 32'h00000013);
      chk("ill out_addr", out_addr, 0);
      chk("ill err_ill", err_ill, 0);
`endif
      drive(v_subi, 1'b0);
      cyc();
`ifdef ENC_ILLEGAL_CHECK_EN
      chk("subi out_valid", out_valid, 0);
      chk("subi out_addr", out_addr, 0);
`else
      chk("subi out_instr", out_instr, 32'h00000013);
      chk("subi out_addr", out_addr, 1);
`endif
      drive(vecs[0], 1'b1);
      cyc();
      chk("post-ill out_instr", out_instr, vecs[0].exp);
`ifdef ENC_ILLEGAL_CHECK_EN
      chk("post-ill out_addr", out_addr, 0);
`else
      chk("post-ill out_addr", out_addr, 2);
`endif
      in_valid = 1'b0;
      cyc();
      chk("ill done", done, 1);
`ifdef ENC_ILLEGAL_CHECK_EN
      chk("ill err_ill sticky", err_ill, 1);
`else
      chk("ill err_ill sticky", err_ill, 0);
`endif
      start = 1'b1; cyc(); start = 1'b0;
      chk("start clears err_ill", err_ill, 0);
      chk("start clears done", done, 0);
      drive(v_ill, 1'b1);
      cyc();
      in_valid = 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      chk("ill-last out_valid", out_valid, 0);
`else
      chk("ill-last out_instr", out_instr, 32'h00000013);
`endif
      chk("ill-last in_ready", in_ready, 0);
      cyc();
      chk("ill-last done", done, 1);

      // Asynchronous reset discards a buffered word
      start = 1'b1; cyc(); start = 1'b0;
      out_ready = 1'b0;
      drive(vecs[3], 1'b0);
      cyc();
      in_valid = 1'b0;
      chk("pre-rst out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", out_valid, 0);
      chk("async rst out_instr", out_instr, 0);
      chk("async rst in_ready", in_ready, 0);
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Address exhaustion on the ADDR_W=2 instance
      start = 1'b1; cyc(); start = 1'b0;
      drive(vecs[0], 1'b0);
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         if (in_ready_s) acc++;
         cyc();
         chk($sformatf("ovf%0d out_valid", k), out_valid_s, 1);
         chk($sformatf("ovf%0d out_addr", k), out_addr_s, k);
         chk($sformatf("ovf%0d out_instr", k), out_instr_s, vecs[0].exp);
      end
      chk("ovf top in_ready", in_ready_s, 0);
      cyc();
      chk("ovf accepted", acc, 4);
      chk("ovf done", done_s, 1);
      chk("ovf err_ovf", err_ovf_s, 1);
      chk("ovf out_valid", out_valid_s, 0);
      chk("ovf in_ready", in_ready_s, 0);
      chk("ovf out_addr", out_addr_s, 3);
      in_valid = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      chk("ovf restart out_addr", out_addr_s, 0);
      chk("ovf restart done", done_s, 0);
      chk("ovf restart err_ovf", err_ovf_s, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
